// File: rtl/conv_exec_pkg.sv
// Shared constants and helpers for the conv-layer output stage.
package conv_exec_pkg;

  // Default widths used by the top-level parameters.
  localparam int unsigned DEF_MAC_W  = 23;
  localparam int unsigned DEF_ACC_W  = 32;
  localparam int unsigned DEF_DATA_W = 16;

  // Width of the intermediate used for bias add, shift and saturation.
  // Wide enough that acc + bias can never wrap before saturation.
  localparam int unsigned SAT_W = 64;

  // Clamp a signed value to the range of a data_w-bit signed number.
  // The result is still SAT_W wide; callers keep the low data_w bits.
  function automatic logic signed [SAT_W-1:0] sat_to_data(input logic signed [SAT_W-1:0] v,
                                                         input int unsigned data_w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

  // Flat index of lane j of output channel k in the packed MAC bus.
  function automatic int unsigned lane_idx(input int unsigned k, input int unsigned j,
                                           input int unsigned in_ch);
    return k * in_ch + j;
  endfunction

endpackage

// File: rtl/conv_exec_acc_if.sv
// Beat input, bias write port and result output of conv_exec_acc.
// master = producer/consumer side (MAC array, RAM writer); slave = conv_exec_acc.
interface conv_exec_acc_if #(
  parameter int unsigned OUT_CH = 16,
  parameter int unsigned IN_CH  = 6,
  parameter int unsigned MAC_W  = 23,
  parameter int unsigned DATA_W = 16
) ();

  localparam int unsigned ADDR_W = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;

  // MAC beat stream
  logic                            in_valid;
  logic                            in_ready;
  logic                            in_first;
  logic                            in_last;
  logic [OUT_CH*IN_CH*MAC_W-1:0]   mac_in;

  // Bias write port
  logic                            bias_we;
  logic [ADDR_W-1:0]               bias_addr;
  logic [DATA_W-1:0]               bias_wdata;

  // Result stream
  logic                            out_valid;
  logic                            out_ready;
  logic [OUT_CH*DATA_W-1:0]        out_data;

  modport master (
    output in_valid, in_first, in_last, mac_in,
    output bias_we, bias_addr, bias_wdata,
    output out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_first, in_last, mac_in,
    input  bias_we, bias_addr, bias_wdata,
    input  out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/conv_lane_sum.sv
// Registered signed sum of IN_CH MAC lanes, sign-extended to ACC_W.
// Written as a chain; synthesis rebalances it into a tree.
module conv_lane_sum #(
  parameter int unsigned IN_CH = 6,
  parameter int unsigned MAC_W = 23,
  parameter int unsigned ACC_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [IN_CH*MAC_W-1:0]   lanes,
  output logic signed [ACC_W-1:0]  sum
);

  logic signed [ACC_W-1:0] sum_d;

  // Combinational lane adder
  always_comb begin
    sum_d = '0;
    for (int j = 0; j < IN_CH; j++) begin
      sum_d = sum_d + {{(ACC_W-MAC_W){lanes[j*MAC_W+MAC_W-1]}}, lanes[j*MAC_W +: MAC_W]};
    end
  end

  // Capture the sum when a beat is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum_d;
    end
  end

endmodule

// File: rtl/conv_exec_acc.sv
// Conv-layer output stage: per-channel lane sum (S1), multi-pass accumulate,
// bias add, arithmetic shift and saturation (S2), with valid/ready on both sides.
// Optional macro CONV_EXEC_RELU_EN clamps negative results to zero after saturation.
module conv_exec_acc
  import conv_exec_pkg::*;
#(
  parameter int unsigned OUT_CH    = 16,
  parameter int unsigned IN_CH     = 6,
  parameter int unsigned MAC_W     = DEF_MAC_W,
  parameter int unsigned ACC_W     = DEF_ACC_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned OUT_SHIFT = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  conv_exec_acc_if.slave bus
);

  localparam int unsigned ADDR_W = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;

  logic stall;
  logic accept;
  logic finalize;

  logic s1_valid_q;
  logic s1_first_q;
  logic s1_last_q;

  logic signed [DATA_W-1:0] bias_q   [OUT_CH];
  logic        [DATA_W-1:0] result   [OUT_CH];
  logic        [DATA_W-1:0] out_data_q [OUT_CH];
  logic                     out_valid_q;

  // A finished pixel waiting in S1 cannot retire while the output is blocked.
  assign stall    = s1_valid_q & s1_last_q & out_valid_q & ~bus.out_ready;
  assign accept   = bus.in_valid & ~stall;
  assign finalize = s1_valid_q & s1_last_q & ~stall;

  assign bus.in_ready  = ~stall;
  assign bus.out_valid = out_valid_q;

  // S1 framing flags travel with the registered lane sums
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
    end else if (!stall) begin
      s1_valid_q <= bus.in_valid;
      s1_first_q <= bus.in_valid & bus.in_first;
      s1_last_q  <= bus.in_valid & bus.in_last;
    end
  end

  for (genvar k = 0; k < OUT_CH; k++) begin : g_ch
    logic signed [ACC_W-1:0] s1_sum;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [SAT_W-1:0] total;
    logic signed [SAT_W-1:0] shifted;

    conv_lane_sum #(
      .IN_CH (IN_CH),
      .MAC_W (MAC_W),
      .ACC_W (ACC_W)
    ) u_lane_sum (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (accept),
      .lanes (bus.mac_in[lane_idx(k, 0, IN_CH)*MAC_W +: IN_CH*MAC_W]),
      .sum   (s1_sum)
    );

    // First pass discards any earlier partial sum; wraps mod 2^ACC_W.
    assign acc_next = (s1_first_q ? '0 : acc_q) + s1_sum;

    assign total   = {{(SAT_W-ACC_W){acc_next[ACC_W-1]}}, acc_next}
                   + {{(SAT_W-DATA_W){bias_q[k][DATA_W-1]}}, bias_q[k]};
    assign shifted = total >>> OUT_SHIFT;

`ifdef CONV_EXEC_RELU_EN
    assign result[k] = shifted[SAT_W-1] ? '0 : DATA_W'(sat_to_data(shifted, DATA_W));
`else
    assign result[k] = DATA_W'(sat_to_data(shifted, DATA_W));
`endif

    // Accumulator advances on every retiring beat and clears after the last pass
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q <= '0;
      end else if (s1_valid_q && !stall) begin
        acc_q <= s1_last_q ? '0 : acc_next;
      end
    end
  end

  // Bias table; writes land regardless of stall and are seen one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < OUT_CH; k++) begin
        bias_q[k] <= '0;
      end
    end else if (bus.bias_we) begin
      for (int k = 0; k < OUT_CH; k++) begin
        if (bus.bias_addr == ADDR_W'(k)) begin
          bias_q[k] <= bus.bias_wdata;
        end
      end
    end
  end

  // Output register; a new finalize replaces a result consumed in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      for (int k = 0; k < OUT_CH; k++) begin
        out_data_q[k] <= '0;
      end
    end else if (finalize) begin
      out_valid_q <= 1'b1;
      for (int k = 0; k < OUT_CH; k++) begin
        out_data_q[k] <= result[k];
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Pack channels onto the output bus, channel k at slice k
  always_comb begin
    bus.out_data = '0;
    for (int k = 0; k < OUT_CH; k++) begin
      bus.out_data[k*DATA_W +: DATA_W] = out_data_q[k];
    end
  end

endmodule

// File: tb/tb_conv_exec_acc.sv
// Directed bench for conv_exec_acc with hand-computed expectations.
module tb_conv_exec_acc;

  localparam int unsigned OUT_CH = 16;
  localparam int unsigned IN_CH  = 6;
  localparam int unsigned MAC_W  = 23;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned DATA_W = 16;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_pass;

  conv_exec_acc_if #(
    .OUT_CH (OUT_CH),
    .IN_CH  (IN_CH),
    .MAC_W  (MAC_W),
    .DATA_W (DATA_W)
  ) bus ();

  conv_exec_acc #(
    .OUT_CH    (OUT_CH),
    .IN_CH     (IN_CH),
    .MAC_W     (MAC_W),
    .ACC_W     (ACC_W),
    .DATA_W    (DATA_W),
    .OUT_SHIFT (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] ch_out(input int k);
    logic signed [DATA_W-1:0] v;
    v = bus.out_data[k*DATA_W +: DATA_W];
    return {{(32-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input int k, input logic [MAC_W-1:0] val);
    for (int j = 0; j < IN_CH; j++) begin
      bus.mac_in[(k*IN_CH+j)*MAC_W +: MAC_W] = val;
    end
  endtask

  task automatic bias_write(input int addr, input logic [DATA_W-1:0] data);
    bus.bias_we    = 1'b1;
    bus.bias_addr  = 4'(addr);
    bus.bias_wdata = data;
    tick();
    bus.bias_we    = 1'b0;
  endtask

  // One first&last beat; returns when the result should be on out_data
  task automatic single_pass();
    bus.in_valid = 1'b1;
    bus.in_first = 1'b1;
    bus.in_last  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
    tick();
  endtask

  initial begin
    logic signed [31:0] neg_exp;
    n_checks = 0;
    n_pass   = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_first   = 1'b0;
    bus.in_last    = 1'b0;
    bus.mac_in     = '0;
    bus.bias_we    = 1'b0;
    bus.bias_addr  = '0;
    bus.bias_wdata = '0;
    bus.out_ready  = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_ch0", ch_out(0), 0);
    rst_n = 1'b1;
    tick();

    // Single pass with bias: 6*10 + 256 = 316, visible two cycles after accept
    bias_write(0, 16'h0100);
    set_lanes(0, 23'd10);
    bus.in_valid = 1'b1;
    bus.in_first = 1'b1;
    bus.in_last  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
    check("t1_not_yet", bus.out_valid, 0);
    tick();
    check("t1_valid", bus.out_valid, 1);
    check("t1_ch0", ch_out(0), 316);
    check("t1_ch1", ch_out(1), 0);
    check("t1_ch15", ch_out(15), 0);
    tick();
    check("t1_drained", bus.out_valid, 0);

    // Three passes on ch1: 3 * 6 * 1000 = 18000; ch0 lanes 0 leaves its bias
    bus.mac_in = '0;
    set_lanes(1, 23'd1000);
    bus.in_valid = 1'b1;
    bus.in_first = 1'b1;
    tick();
    check("t2_beat1", bus.out_valid, 0);
    bus.in_first = 1'b0;
    tick();
    check("t2_beat2", bus.out_valid, 0);
    bus.in_last = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("t2_beat3", bus.out_valid, 0);
    tick();
    check("t2_valid", bus.out_valid, 1);
    check("t2_ch1", ch_out(1), 18000);
    check("t2_ch0", ch_out(0), 256);

    // Saturation on ch2
    bus.mac_in = '0;
    set_lanes(2, 23'h100000);
    single_pass();
    check("t3_pos_sat", ch_out(2), 32767);
    set_lanes(2, 23'h700000);
    single_pass();
`ifdef CONV_EXEC_RELU_EN
    neg_exp = 0;
`else
    neg_exp = -32768;
`endif
    check("t3_neg_sat", ch_out(2), neg_exp);

    // Backpressure: two back-to-back single-beat ops with output blocked
    bias_write(0, 16'h0000);
    bus.mac_in = '0;
    set_lanes(0, 23'd1);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_first  = 1'b1;
    bus.in_last   = 1'b1;
    tick();
    set_lanes(0, 23'd2);
    #1;
    check("t4_ready_a", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
    check("t4_stall", bus.in_ready, 0);
    check("t4_valid_a", bus.out_valid, 1);
    check("t4_data_a", ch_out(0), 6);
    tick();
    check("t4_hold_rdy", bus.in_ready, 0);
    check("t4_hold_val", bus.out_valid, 1);
    check("t4_hold_data", ch_out(0), 6);
    bus.out_ready = 1'b1;
    #1;
    check("t4_unstall", bus.in_ready, 1);
    tick();
    check("t4_valid_b", bus.out_valid, 1);
    check("t4_data_b", ch_out(0), 12);
    tick();
    check("t4_drained", bus.out_valid, 0);

    // Bias write coinciding with finalize uses the old bias
    bias_write(3, 16'h0007);
    bus.mac_in = '0;
    set_lanes(3, 23'd1);
    bus.in_valid = 1'b1;
    bus.in_first = 1'b1;
    bus.in_last  = 1'b1;
    tick();
    bus.in_valid   = 1'b0;
    bus.in_first   = 1'b0;
    bus.in_last    = 1'b0;
    bus.bias_we    = 1'b1;
    bus.bias_addr  = 4'd3;
    bus.bias_wdata = 16'hFFFF;
    tick();
    bus.bias_we = 1'b0;
    check("t5_old_bias", ch_out(3), 13);
    single_pass();
    check("t5_new_bias", ch_out(3), 5);

    // Reset mid-operation with a result still pending
    bus.out_ready = 1'b0;
    bus.mac_in = '0;
    set_lanes(0, 23'd5);
    set_lanes(3, 23'd5);
    bus.in_valid = 1'b1;
    bus.in_first = 1'b1;
    tick();
    bus.in_first = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", bus.out_valid, 0);
    check("t6_rst_ready", bus.in_ready, 1);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    // No in_first: must start from a cleared accumulator
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    tick();
    check("t6_valid", bus.out_valid, 1);
    check("t6_ch0", ch_out(0), 30);
    check("t6_ch3_bias0", ch_out(3), 30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
